step_tick_counter: RTL and testbench
====================================

# step_tick_counter

Parametrised programmable-step counter for the model computer's counter/monitor datapath. A single-clock clock-enable divider paces the count, and no derived clocks are generated. Each tick adds or subtracts a programmable step, either wrapping or saturating. A synchronous load has priority over counting. The block drives the count bus plus a mirrored monitor bus, and flags overflow/underflow for the display and control logic.

## Interface
Parameters:
- WIDTH, 8, counter/step/load width
- DIV_WIDTH, 26, divider register width
- DIV_FAST, 2499999, divider terminal value when speed=1 (period DIV_FAST+1 clk)
- DIV_SLOW, 24999999, divider terminal value when speed=0 (period DIV_SLOW+1 clk)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  count enable; 0 freezes divider and count
- speed  in  1  divider terminal select (1 = fast)
- load  in  1  synchronous load of load_value
- load_value  in  WIDTH  value for load
- step  in  WIDTH  unsigned increment per tick
- dir  in  1  0 = up, 1 = down
- sat  in  1  0 = wrap modulo 2^WIDTH, 1 = saturate at 0 / 2^WIDTH-1
- count  out  WIDTH  current count (registered)
- monitor  out  WIDTH  registered mirror of count, always equal to count
- tick  out  1  one-cycle pulse on each count update edge
- ovf  out  1  one-cycle pulse: update overflowed (up) or underflowed (down)

## Operation
- Reset drives the following to 0: count, monitor, tick, ovf, div_cnt.
- Priority per clk edge: rst > load > en-gated counting.
- load=1:
  - count and monitor take load_value; div_cnt is cleared.
  - tick=0, ovf=0. The en value is ignored.
- en=0, load=0:
  - div_cnt, count and monitor hold.
  - tick=0, ovf=0.
- en=1, load=0:
  - Define term = speed ? DIV_FAST : DIV_SLOW.
  - If div_cnt >= term: div_cnt <= 0, tick <= 1, count/monitor <= next, ovf <= flag.
  - Otherwise: div_cnt <= div_cnt+1, tick <= 0, ovf <= 0.
- Arithmetic is computed in WIDTH+1 bits:
  - Up: s = {0,count}+{0,step}; flag = s[WIDTH].
  - Down: s = {0,count}-{0,step}; flag = s[WIDTH] (borrow).
- Wrap (sat=0): next = s[WIDTH-1:0].
- Saturate (sat=1): if flag, next = all-ones (up) or 0 (down); otherwise s[WIDTH-1:0].
- ovf pulses whenever flag=1, including in saturate mode when the count is already at the limit.
- step=0: a tick still occurs, count is unchanged, ovf=0.
- step, dir and sat are sampled only on the tick edge. Changing them between ticks has no other effect.

## Timing
- Tick period is term+1 clk cycles from the load or release of reset, while en stays 1.
- The count update and the tick/ovf pulse appear together, registered, on the same edge. Latency from the terminal div_cnt value is 1 edge.
- Speed switched mid-period:
  - The comparison is >=, so if div_cnt already exceeds the new term, a tick fires on the next enabled edge.
  - Otherwise counting continues to the new term.
- Deasserting en freezes div_cnt. Reasserting it resumes the count without restarting the period.
- Asserting rst mid-period clears everything immediately. The first tick after release is term+1 enabled cycles later.
- Load and terminal count on the same edge: load wins, no tick, and the period restarts.

## Structure
- Shared package/header mc_counter_defs: direction encodings (DIR_UP=0, DIR_DOWN=1) and mode encodings (MODE_WRAP=0, MODE_SAT=1), plus the default divider constants DIV_FAST_DEFAULT and DIV_SLOW_DEFAULT.
- One sub-module, tick_divider (DIV_WIDTH, DIV_FAST, DIV_SLOW):
  - Inputs: clk, rst, en, speed, clr.
  - Outputs: the combinational terminal strobe, and div_cnt for debug.
- The top level holds the step arithmetic, saturation logic and output registers.

## Test plan
All scenarios use WIDTH=8, DIV_FAST=3, DIV_SLOW=9.
- Reset and period: rst pulse, en=1, speed=1, step=1, dir=0. count=0 during reset; tick every 4 clk; count 1,2,3 on successive ticks.
- Wrap up: load 250, step=10, sat=0, dir=0. Next tick count=4, ovf=1 for one cycle; following tick count=14, ovf=0.
- Saturate down: load 5, step=3, dir=1, sat=1. Ticks give 2, then 0 with ovf=1, then 0 with ovf=1 again.
- Speed switch: speed=0, and div_cnt reaches 6 with en=1. Set speed=1; tick fires on the next edge, then every 4 clk.
- Load priority: load=1 with load_value=0x80 on the same edge as the terminal count. count=0x80, tick=0; next tick 4 clk later.
- Enable hold and async reset: en=0 for 20 clk, so count and div_cnt are frozen. Assert rst between clk edges; count, monitor, tick and ovf go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mc_counter_defs.sv
// Shared encodings and default divider constants for the model computer's
// counter/monitor datapath.
package mc_counter_defs;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

   // Terminal values for a 10 Hz / 1 Hz tick from a 25 MHz system clock.
   localparam int DIV_FAST_DEFAULT = 2499999;
   localparam int DIV_SLOW_DEFAULT = 24999999;

endpackage

// File: rtl/tick_divider.sv
// Clock-enable divider: counts enabled cycles and raises a combinational
// strobe once div_cnt reaches the selected terminal value.
module tick_divider #(
   parameter int DIV_WIDTH = 26,
   parameter int DIV_FAST  = 2499999,
   parameter int DIV_SLOW  = 24999999
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 speed,
   input  logic                 clr,
   output logic                 term_hit,
   output logic [DIV_WIDTH-1:0] div_cnt
);

   localparam logic [DIV_WIDTH-1:0] TERM_FAST = DIV_WIDTH'(DIV_FAST);
   localparam logic [DIV_WIDTH-1:0] TERM_SLOW = DIV_WIDTH'(DIV_SLOW);
   localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);

   logic [DIV_WIDTH-1:0] term_s;
   logic [DIV_WIDTH-1:0] div_cnt_d;
   logic [DIV_WIDTH-1:0] div_cnt_q;

   // Terminal select; >= so a switch to a shorter period fires promptly.
   always_comb begin
      term_s   = speed ? TERM_FAST : TERM_SLOW;
      term_hit = en & (div_cnt_q >= term_s);
   end

   // Next divider value: clear wins, then wrap on terminal, else advance or hold.
   always_comb begin
      div_cnt_d = div_cnt_q;
      if (clr) begin
         div_cnt_d = {DIV_WIDTH{1'b0}};
      end else if (term_hit) begin
         div_cnt_d = {DIV_WIDTH{1'b0}};
      end else if (en) begin
         div_cnt_d = div_cnt_q + ONE;
      end else begin
         div_cnt_d = div_cnt_q;
      end
   end

   // Divider state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q <= {DIV_WIDTH{1'b0}};
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   assign div_cnt = div_cnt_q;

endmodule

// File: rtl/step_tick_counter.sv
// Programmable-step counter paced by tick_divider; adds or subtracts step on
// each tick with wrap or saturate, and flags overflow/underflow.
module step_tick_counter
   import mc_counter_defs::*;
#(
   parameter int WIDTH     = 8,
   parameter int DIV_WIDTH = 26,
   parameter int DIV_FAST  = DIV_FAST_DEFAULT,
   parameter int DIV_SLOW  = DIV_SLOW_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             speed,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic [WIDTH-1:0] step,
   input  logic             dir,
   input  logic             sat,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] monitor,
   output logic             tick,
   output logic             ovf
);

   logic                 term_hit_s;
   logic [DIV_WIDTH-1:0] div_cnt_unused_s;
   logic [WIDTH:0]       sum_s;
   logic                 flag_s;
   logic [WIDTH-1:0]     next_s;

   logic [WIDTH-1:0] count_d,   count_q;
   logic [WIDTH-1:0] monitor_d, monitor_q;
   logic             tick_d,    tick_q;
   logic             ovf_d,     ovf_q;

   tick_divider #(
      .DIV_WIDTH (DIV_WIDTH),
      .DIV_FAST  (DIV_FAST),
      .DIV_SLOW  (DIV_SLOW)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .speed    (speed),
      .clr      (load),
      .term_hit (term_hit_s),
      .div_cnt  (div_cnt_unused_s)
   );

   // One extra bit carries the overflow (up) or borrow (down) out of the step.
   always_comb begin
      if (dir == DIR_DOWN) begin
         sum_s = {1'b0, count_q} - {1'b0, step};
      end else begin
         sum_s = {1'b0, count_q} + {1'b0, step};
      end
      flag_s = sum_s[WIDTH];
      if ((sat == MODE_SAT) && flag_s) begin
         if (dir == DIR_DOWN) begin
            next_s = {WIDTH{1'b0}};
         end else begin
            next_s = {WIDTH{1'b1}};
         end
      end else begin
         next_s = sum_s[WIDTH-1:0];
      end
   end

   // Output update: load has priority over a tick; pulses default low.
   always_comb begin
      count_d   = count_q;
      monitor_d = monitor_q;
      tick_d    = 1'b0;
      ovf_d     = 1'b0;
      if (load) begin
         count_d   = load_value;
         monitor_d = load_value;
      end else if (term_hit_s) begin
         count_d   = next_s;
         monitor_d = next_s;
         tick_d    = 1'b1;
         ovf_d     = flag_s;
      end else begin
         count_d   = count_q;
         monitor_d = monitor_q;
      end
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= {WIDTH{1'b0}};
         monitor_q <= {WIDTH{1'b0}};
         tick_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         count_q   <= count_d;
         monitor_q <= monitor_d;
         tick_q    <= tick_d;
         ovf_q     <= ovf_d;
      end
   end

   assign count   = count_q;
   assign monitor = monitor_q;
   assign tick    = tick_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_step_tick_counter.sv
// Scoreboard bench for step_tick_counter: directed scenarios then random
// stimulus, checked against an integer-arithmetic reference model.
module tb_step_tick_counter;

   localparam int W     = 8;
   localparam int TFAST = 3;
   localparam int TSLOW = 9;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         speed = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] load_value = '0;
   logic [W-1:0] step = '0;
   logic         dir = 1'b0;
   logic         sat = 1'b0;
   logic [W-1:0] count;
   logic [W-1:0] monitor;
   logic         tick;
   logic         ovf;

   step_tick_counter #(
      .WIDTH     (W),
      .DIV_WIDTH (4),
      .DIV_FAST  (TFAST),
      .DIV_SLOW  (TSLOW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .speed      (speed),
      .load       (load),
      .load_value (load_value),
      .step       (step),
      .dir        (dir),
      .sat        (sat),
      .count      (count),
      .monitor    (monitor),
      .tick       (tick),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cnt;
      bit tick;
      bit ovf;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   m_cnt = 0;
   int   m_phase = 0;
   int   m_ticks = 0;
   int   seen_ticks = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: one edge of behaviour from the rules, in plain integers.
   task automatic model_push();
      exp_t e;
      int   v;
      int   term;
      e.tick = 1'b0;
      e.ovf  = 1'b0;
      if (rst) begin
         m_cnt   = 0;
         m_phase = 0;
      end else if (load) begin
         m_cnt   = int'(load_value);
         m_phase = 0;
      end else if (en) begin
         term = speed ? TFAST : TSLOW;
         if (m_phase >= term) begin
            m_phase = 0;
            e.tick  = 1'b1;
            v = dir ? m_cnt - int'(step) : m_cnt + int'(step);
            e.ovf = (v < 0) || (v > 255);
            if (!e.ovf)   m_cnt = v;
            else if (sat) m_cnt = dir ? 0 : 255;
            else          m_cnt = (v + 256) % 256;
            m_ticks++;
         end else begin
            m_phase++;
         end
      end
      e.cnt = m_cnt;
      sb.push_back(e);
   endtask

   // Called at negedge+1: record the expectation, then step through one edge.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         model_push();
         @(posedge clk);
         @(negedge clk);
         #1;
      end
   endtask

   // Monitor: every edge presents an output; pop and compare on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("count", int'(count), e.cnt);
         chk("monitor", int'(monitor), e.cnt);
         chk("tick", int'(tick), int'(e.tick));
         chk("ovf", int'(ovf), int'(e.ovf));
         if (tick) seen_ticks++;
      end
   end

   initial begin
      int guard;
      @(negedge clk);
      #1;
      chk("reset_count", int'(count), 0);
      chk("reset_tick", int'(tick), 0);
      // Reset and period
      cyc(2);
      rst = 1'b0; en = 1'b1; speed = 1'b1; step = 8'd1; dir = 1'b0; sat = 1'b0;
      cyc(12);
      chk("period_count", int'(count), 3);
      // Wrap up
      load = 1'b1; load_value = 8'd250; step = 8'd10;
      cyc(1);
      load = 1'b0;
      cyc(8);
      chk("wrap_count", int'(count), 14);
      // Saturate down
      load = 1'b1; load_value = 8'd5; step = 8'd3; dir = 1'b1; sat = 1'b1;
      cyc(1);
      load = 1'b0;
      cyc(12);
      chk("satdown_count", int'(count), 0);
      // Speed switch while the slow divider is at 6
      speed = 1'b0; load = 1'b1; load_value = 8'd0; dir = 1'b0; sat = 1'b0; step = 8'd1;
      cyc(1);
      load = 1'b0;
      guard = 0;
      while (m_phase != 6 && guard < 40) begin cyc(1); guard++; end
      chk("reach_div6", m_phase, 6);
      speed = 1'b1;
      cyc(9);
      chk("switch_count", int'(count), 3);
      // Load coinciding with terminal count
      guard = 0;
      while (m_phase != TFAST && guard < 40) begin cyc(1); guard++; end
      chk("reach_term", m_phase, TFAST);
      load = 1'b1; load_value = 8'h80;
      cyc(1);
      load = 1'b0;
      chk("load_pri_count", int'(count), 128);
      chk("load_pri_tick", int'(tick), 0);
      cyc(4);
      chk("after_load_count", int'(count), 129);
      // Enable hold then asynchronous reset between edges
      cyc(2);
      en = 1'b0;
      cyc(20);
      chk("hold_count", int'(count), 129);
      en = 1'b1;
      cyc(3);
      rst = 1'b1;
      #1;
      chk("async_count", int'(count), 0);
      chk("async_monitor", int'(monitor), 0);
      chk("async_tick", int'(tick), 0);
      chk("async_ovf", int'(ovf), 0);
      cyc(2);
      rst = 1'b0;
      // Random phase
      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom_range(0, 499) == 0);
         en   = ($urandom_range(0, 7) != 0);
         load = ($urandom_range(0, 39) == 0);
         load_value = W'($urandom);
         if ($urandom_range(0, 49) == 0) speed = ~speed;
         if ($urandom_range(0, 29) == 0) dir = W'($urandom) > 8'd127;
         if ($urandom_range(0, 29) == 0) sat = ~sat;
         case ($urandom_range(0, 3))
            0: step = 8'd0;
            1: step = W'($urandom_range(1, 4));
            2: step = W'($urandom_range(100, 255));
            default: step = W'($urandom);
         endcase
         cyc(1);
      end
      chk("queue_drained", sb.size(), 0);
      chk("tick_total", seen_ticks, m_ticks);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
